// File: rtl/hololink_init_seq.sv
// hololink_init_seq: post-reset APB write sequencer that walks an {addr,data} table once per run.
module hololink_init_seq #(
  parameter int N_INIT_REG  = 20,
  parameter int START_DELAY = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                                            i_apb_clk,
  input  logic                                            i_apb_rst,
  input  logic [64*(N_INIT_REG > 0 ? N_INIT_REG : 1)-1:0] i_init_table,
  input  logic                                            i_restart,
  output logic                                            o_psel,
  output logic                                            o_penable,
  output logic                                            o_pwrite,
  output logic [31:0]                                     o_paddr,
  output logic [31:0]                                     o_pwdata,
  output logic [3:0]                                      o_pstrb,
  input  logic                                            i_pready,
  input  logic                                            i_pslverr,
  output logic                                            o_busy,
  output logic                                            o_init_done,
  output logic                                            o_init_err,
  output logic [7:0]                                      o_err_cnt
);
  typedef enum logic [1:0] {WAIT, SETUP, ACCESS, DONE} state_t;
  state_t state;
  logic [31:0] dcnt, idx, nxt;
  logic [7:0] tcnt;
  logic [63:0] entry;
  logic last, exit_acc, fail;
  // The entry for the next SETUP is captured on the edge that enters it, so the
  // table may change freely while a write is in flight.
  always_comb begin
    last = idx == 32'(N_INIT_REG - 1);
    nxt = (state == ACCESS && !last) ? idx + 32'd1 : '0;
    entry = i_init_table[64*nxt +: 64];
    exit_acc = i_pready || tcnt == 8'(TIMEOUT - 1);
    fail = !i_pready || i_pslverr;
  end
  assign o_pwrite = o_psel;
  assign o_pstrb = {4{o_psel}};
  always_ff @(posedge i_apb_clk) begin
    if (i_apb_rst) begin
      state <= WAIT;
      dcnt <= '0;
      tcnt <= '0;
      idx <= '0;
      o_psel <= 1'b0;
      o_penable <= 1'b0;
      o_paddr <= '0;
      o_pwdata <= '0;
      o_busy <= 1'b1;
      o_init_done <= 1'b0;
      o_init_err <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (dcnt == 32'(START_DELAY)) begin
            if (N_INIT_REG == 0) begin
              state <= DONE;
              o_busy <= 1'b0;
              o_init_done <= 1'b1;
            end else begin
              state <= SETUP;
              o_psel <= 1'b1;
              tcnt <= '0;
              o_paddr <= entry[63:32];
              o_pwdata <= entry[31:0];
            end
          end else dcnt <= dcnt + 32'd1;
        end
        SETUP: begin
          state <= ACCESS;
          o_penable <= 1'b1;
        end
        ACCESS: begin
          if (exit_acc) begin
            if (fail) begin
              o_init_err <= 1'b1;
              o_err_cnt <= (o_err_cnt == 8'hFF) ? o_err_cnt : o_err_cnt + 8'd1;
            end
            o_penable <= 1'b0;
            if (last) begin
              state <= DONE;
              o_psel <= 1'b0;
              o_busy <= 1'b0;
              o_init_done <= 1'b1;
            end else begin
              state <= SETUP;
              idx <= nxt;
              tcnt <= '0;
              o_paddr <= entry[63:32];
              o_pwdata <= entry[31:0];
            end
          end else tcnt <= tcnt + 8'd1;
        end
        DONE: begin
          if (i_restart) begin
            state <= WAIT;
            dcnt <= '0;
            idx <= '0;
            o_busy <= 1'b1;
            o_init_done <= 1'b0;
            o_init_err <= 1'b0;
            o_err_cnt <= '0;
          end
        end
        default: state <= WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_hololink_init_seq.sv
// tb_hololink_init_seq: directed/randomized runs against a per-entry timing and error model.
module tb_hololink_init_seq;
  localparam int N = 20, D = 16, T = 255;
  logic clk = 0, rst = 1, restart = 0, pready = 0, pslverr = 0;
  logic [64*N-1:0] tbl, ref_tbl;
  logic psel, penable, pwrite, busy, done, err;
  logic [31:0] paddr, pwdata;
  logic [3:0] pstrb;
  logic [7:0] err_cnt;
  logic rst0 = 1;
  logic psel0, penable0, pwrite0, busy0, done0, err0;
  logic [31:0] paddr0, pwdata0;
  logic [3:0] pstrb0;
  logic [7:0] err_cnt0;
  int total = 0, bad = 0;
  int wt[N], er[N], acc_len[N];
  logic [63:0] obs[$];
  bit mutate = 0;

  always #5 clk = ~clk;

  hololink_init_seq #(.N_INIT_REG(N), .START_DELAY(D), .TIMEOUT(T)) dut (
    .i_apb_clk(clk), .i_apb_rst(rst), .i_init_table(tbl), .i_restart(restart),
    .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite), .o_paddr(paddr),
    .o_pwdata(pwdata), .o_pstrb(pstrb), .i_pready(pready), .i_pslverr(pslverr),
    .o_busy(busy), .o_init_done(done), .o_init_err(err), .o_err_cnt(err_cnt));

  hololink_init_seq #(.N_INIT_REG(0), .START_DELAY(D), .TIMEOUT(T)) dut0 (
    .i_apb_clk(clk), .i_apb_rst(rst0), .i_init_table(64'h0), .i_restart(1'b0),
    .o_psel(psel0), .o_penable(penable0), .o_pwrite(pwrite0), .o_paddr(paddr0),
    .o_pwdata(pwdata0), .o_pstrb(pstrb0), .i_pready(1'b0), .i_pslverr(1'b0),
    .o_busy(busy0), .o_init_done(done0), .o_init_err(err0), .o_err_cnt(err_cnt0));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Slave: answers each ACCESS after wt[k] wait states, flags er[k] with pready.
  initial forever begin
    @(negedge clk);
    if (psel && !penable) begin
      obs.push_back({paddr, pwdata});
      pready = 0;
      pslverr = 0;
    end else if (psel && penable && obs.size() > 0) begin
      automatic int k = obs.size() - 1;
      automatic int a = (acc_len[k] < 0) ? 0 : acc_len[k];
      chk("hold", {paddr, pwdata}, obs[k]);
      chk("wr_strb", {59'd0, pwrite, pstrb}, 64'h1F);
      acc_len[k] = a + 1;
      pready = (a == wt[k]);
      pslverr = pready && er[k] != 0;
      if (mutate && a == 0) tbl[64*k +: 64] = ~tbl[64*k +: 64];
    end else begin
      pready = 0;
      pslverr = 0;
    end
  end

  task automatic cfg(input int mode);
    for (int k = 0; k < N; k++) begin
      tbl[64*k +: 64] = {$urandom, $urandom};
      wt[k] = (mode == 4) ? $urandom_range(0, 4) : 0;
      er[k] = (mode == 4) ? int'($urandom_range(0, 3) == 0) : 0;
      acc_len[k] = -1;
    end
    if (mode == 2) wt[5] = 3;
    if (mode == 3) begin er[2] = 1; er[7] = 1; end
    if (mode == 5) wt[0] = 1000;
    ref_tbl = tbl;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus", {psel, penable, pwrite, pstrb, paddr, pwdata}, 0);
    chk("rst_stat", {busy, done, err, err_cnt}, {1'b1, 10'd0});
    obs.delete();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_done(input int pulse_at, output int cyc, output int first, output int idle);
    first = -1;
    idle = 0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk);
      #1;
      restart = (cyc == pulse_at);
      if (done) break;
      if (psel && first < 0) first = cyc;
      if (!psel && first >= 0) idle++;
    end
    restart = 0;
    chk("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic check_run(input string tag, input int cyc, input int first, input int idle);
    int exp_done = D, exp_errs = 0, mism = 0;
    for (int k = 0; k < N; k++) begin
      exp_done += 1 + ((wt[k] >= T) ? T : wt[k] + 1);
      if (wt[k] >= T || er[k] != 0) exp_errs++;
      if (k >= obs.size() || obs[k] !== ref_tbl[64*k +: 64]) mism++;
    end
    chk({tag, "_done_cyc"}, 64'(cyc), 64'(exp_done));
    chk({tag, "_first"}, 64'(first), 64'(D));
    chk({tag, "_idle"}, 64'(idle), 0);
    chk({tag, "_nwr"}, 64'(obs.size()), 64'(N));
    chk({tag, "_wrdata"}, 64'(mism), 0);
    chk({tag, "_errcnt"}, {56'd0, err_cnt}, 64'(exp_errs));
    chk({tag, "_err"}, {63'd0, err}, {63'd0, exp_errs > 0});
    chk({tag, "_busy"}, {63'd0, busy}, 0);
  endtask

  initial begin
    int cyc, first, idle;
    cfg(1); do_reset(); wait_done(-1, cyc, first, idle); check_run("t1", cyc, first, idle);
    cfg(2); do_reset(); wait_done(-1, cyc, first, idle); check_run("t2", cyc, first, idle);
    chk("t2_acc5", 64'(acc_len[5]), 4);
    cfg(3); do_reset(); wait_done(-1, cyc, first, idle); check_run("t3", cyc, first, idle);
    cfg(5); do_reset(); wait_done(-1, cyc, first, idle); check_run("t4", cyc, first, idle);
    chk("t4_acc0", 64'(acc_len[0]), 64'(T));
    chk("t4_acc1", 64'(acc_len[1]), 1);
    // Random slave behaviour, table changes mid-write, restart ignored mid-run.
    cfg(4); mutate = 1; do_reset(); wait_done(30, cyc, first, idle); mutate = 0;
    check_run("rnd", cyc, first, idle);
    // Restart from DONE re-runs the table with fresh slave behaviour.
    cfg(4);
    @(negedge clk); restart = 1; @(posedge clk); #1; restart = 0;
    chk("rs_stat", {busy, done, err, err_cnt}, {1'b1, 10'd0});
    obs.delete();
    @(negedge clk);
    wait_done(-1, cyc, first, idle); check_run("rs", cyc, first, idle);
    // Reset during ACCESS of entry 10.
    cfg(1); do_reset();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (obs.size() == 11 && penable) break;
    end
    chk("t5_in_acc", {62'd0, psel, penable}, 3);
    rst = 1;
    @(posedge clk); #1;
    chk("t5_abort", {62'd0, psel, penable}, 0);
    cfg(1); do_reset(); wait_done(-1, cyc, first, idle); check_run("t5", cyc, first, idle);
    // Empty table build.
    begin
      int seen = 0, c;
      rst0 = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("n0_rst", {busy0, done0, psel0}, 3'b100);
      @(negedge clk); rst0 = 0;
      for (c = 0; c < 200; c++) begin
        @(posedge clk); #1;
        if (psel0) seen++;
        if (done0) break;
      end
      chk("n0_done_cyc", 64'(c), 64'(D));
      chk("n0_psel", 64'(seen), 0);
      chk("n0_stat", {busy0, done0, err0, err_cnt0}, {2'b01, 9'd0});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
